unidad_control_multiciclo: RTL and testbench
============================================

UNIDAD_CONTROL_MULTICICLO -- requirements
Module: unidad_control_multiciclo

Interface
REQ-001 Parameter: RET_W, default 16, width of retired-instruction counter.
REQ-002 CLK  input  1  system clock, all state updates on rising edge.
REQ-003 Reset  input  1  synchronous, active-high reset.
REQ-004 opcode  input  7  instr[6:0] from instruction register.
REQ-005 funct3  input  3  instr[14:12].
REQ-006 funct7b5  input  1  instr[30].
REQ-007 Zero  input  1  ALU zero flag.
REQ-008 mem_ready  input  1  memory access complete this cycle.
REQ-009 PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite  output  1 each  datapath enables/selects.
REQ-010 ALUSrcA, ALUSrcB, ResultSrc  output  2 each  mux selects.
REQ-011 ALUControl  output  3  000 add, 001 sub, 010 and, 011 or, 101 slt.
REQ-012 illegal_instr  output  1  one-cycle pulse on unsupported opcode.
REQ-013 retired  output  RET_W  count of completed instructions.

Function
REQ-014 Moore FSM states: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL, ILLEGAL.
REQ-015 FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=00, ALUSrcB=10, add, ResultSrc=10, PCWrite=1 only in cycle mem_ready=1; hold FETCH with IRWrite/PCWrite=0 while mem_ready=0.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, add (branch target); next by opcode: 0000011/0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL, other->ILLEGAL.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, add; lw->MEMREAD, sw->MEMWRITE.
REQ-018 MEMREAD: ResultSrc=00, AdrSrc=1; wait for mem_ready=1, then MEMWB.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1; ->FETCH.
REQ-020 MEMWRITE: ResultSrc=00, AdrSrc=1, MemWrite=1 held until mem_ready=1, then ->FETCH.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00; ALUControl from funct3: 000 add (sub if funct7b5=1), 111 and, 110 or, 010 slt; ->ALUWB.
REQ-022 EXECI: ALUSrcA=10, ALUSrcB=01; same funct3 decode, funct7b5 ignored (never sub); ->ALUWB.
REQ-023 Unsupported funct3 in EXECR/EXECI decodes as add (no trap).
REQ-024 ALUWB: ResultSrc=00, RegWrite=1; ->FETCH.
REQ-025 BEQ: ALUSrcA=10, ALUSrcB=00, sub, ResultSrc=00, PCWrite=Zero; ->FETCH.
REQ-026 JAL: ALUSrcA=01, ALUSrcB=10, add, ResultSrc=00, PCWrite=1, then ->ALUWB (writes rd=PC+4).
REQ-027 ILLEGAL: illegal_instr=1 one cycle, no writes; ->FETCH.
REQ-028 Unlisted enables/selects are 0 in each state.
REQ-029 Latency (mem_ready tied 1): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles.
REQ-030 retired increments by 1 on the cycle leaving MEMWB, MEMWRITE(ready), ALUWB, BEQ; not ILLEGAL, not JAL->ALUWB transit twice (JAL counted once at ALUWB); wraps 2^RET_W-1->0.
REQ-031 Next state is a function of registered state and inputs sampled at the same edge; no combinational path from outputs back to inputs.

Reset
REQ-032 Reset=1 at rising edge: state<=FETCH, retired<=0, regardless of current state (including mid-MEMWRITE).
REQ-033 While Reset=1 all outputs 0, ALUControl=000; first fetch on first edge after Reset deasserts.

Verification
REQ-034 Reset 1 cycle, mem_ready=1, opcode 0110011 funct3=000 funct7b5=1 -> FETCH,DECODE,EXECR(ALUControl=001),ALUWB(RegWrite=1); retired=1.
REQ-035 lw with mem_ready low 3 cycles in MEMREAD -> MEMREAD held 4 cycles, RegWrite only in MEMWB, total 8 cycles.
REQ-036 beq with Zero=1 then Zero=0 -> PCWrite=1 in first BEQ cycle, 0 in second; retired=2.
REQ-037 opcode 1111111 -> illegal_instr pulse 1 cycle at cycle 3, no RegWrite/MemWrite, retired unchanged.
REQ-038 Reset asserted in MEMWRITE with mem_ready=0 -> MemWrite=0 same cycle, next state FETCH, retired=0.
REQ-039 RET_W=4, 17 R-type instructions -> retired wraps to 1.

Source files
------------

// File: rtl/unidad_control_multiciclo.sv
// Multicycle RISC-V control unit: FSM sequencing fetch/decode/execute/memory/writeback
// with datapath enables, mux selects, ALU operation and a retired-instruction counter.
module unidad_control_multiciclo #(
    parameter int RET_W = 16
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             funct7b5,
    input  logic             Zero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             IRWrite,
    output logic             AdrSrc,
    output logic             MemWrite,
    output logic             RegWrite,
    output logic [1:0]       ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [1:0]       ResultSrc,
    output logic [2:0]       ALUControl,
    output logic             illegal_instr,
    output logic [RET_W-1:0] retired
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10,
        S_ILLEGAL  = 4'd11
    } state_t;

    localparam logic [6:0] OP_LW   = 7'b0000011;
    localparam logic [6:0] OP_SW   = 7'b0100011;
    localparam logic [6:0] OP_R    = 7'b0110011;
    localparam logic [6:0] OP_I    = 7'b0010011;
    localparam logic [6:0] OP_BEQ  = 7'b1100011;
    localparam logic [6:0] OP_JAL  = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    state_t             state_q, state_d;
    logic [RET_W-1:0]   retired_q, retired_d;

    logic               pc_write_s, ir_write_s, adr_src_s, mem_write_s, reg_write_s;
    logic [1:0]         alu_src_a_s, alu_src_b_s, result_src_s;
    logic [2:0]         alu_control_s;
    logic               illegal_s;

    // Unsupported funct3 falls through to add rather than trapping.
    function automatic logic [2:0] alu_decode(input logic [2:0] f3, input logic sub_en);
        logic [2:0] op;
        case (f3)
            3'b000:  op = sub_en ? ALU_SUB : ALU_ADD;
            3'b111:  op = ALU_AND;
            3'b110:  op = ALU_OR;
            3'b010:  op = ALU_SLT;
            default: op = ALU_ADD;
        endcase
        return op;
    endfunction

    // State and retired-counter registers with synchronous reset.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state_q   <= S_FETCH;
            retired_q <= {RET_W{1'b0}};
        end else begin
            state_q   <= state_d;
            retired_q <= retired_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_FETCH:    state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXECR;
                    OP_I:         state_d = S_EXECI;
                    OP_BEQ:       state_d = S_BEQ;
                    OP_JAL:       state_d = S_JAL;
                    default:      state_d = S_ILLEGAL;
                endcase
            end
            S_MEMADR:   state_d = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            S_MEMREAD:  state_d = mem_ready ? S_MEMWB : S_MEMREAD;
            S_MEMWB:    state_d = S_FETCH;
            S_MEMWRITE: state_d = mem_ready ? S_FETCH : S_MEMWRITE;
            S_EXECR:    state_d = S_ALUWB;
            S_EXECI:    state_d = S_ALUWB;
            S_ALUWB:    state_d = S_FETCH;
            S_BEQ:      state_d = S_FETCH;
            S_JAL:      state_d = S_ALUWB;
            S_ILLEGAL:  state_d = S_FETCH;
            default:    state_d = S_FETCH;
        endcase
    end

    // JAL itself never counts; its retirement happens on the ALUWB it passes through.
    always_comb begin
        retired_d = retired_q;
        case (state_q)
            S_MEMWB, S_ALUWB, S_BEQ: retired_d = retired_q + RET_W'(1);
            S_MEMWRITE: begin
                if (mem_ready) begin
                    retired_d = retired_q + RET_W'(1);
                end else begin
                    retired_d = retired_q;
                end
            end
            default:                 retired_d = retired_q;
        endcase
    end

    // Per-state control outputs; anything not set stays zero.
    always_comb begin
        pc_write_s    = 1'b0;
        ir_write_s    = 1'b0;
        adr_src_s     = 1'b0;
        mem_write_s   = 1'b0;
        reg_write_s   = 1'b0;
        alu_src_a_s   = 2'b00;
        alu_src_b_s   = 2'b00;
        result_src_s  = 2'b00;
        alu_control_s = ALU_ADD;
        illegal_s     = 1'b0;
        case (state_q)
            S_FETCH: begin
                ir_write_s   = mem_ready;
                pc_write_s   = mem_ready;
                alu_src_b_s  = 2'b10;
                result_src_s = 2'b10;
            end
            S_DECODE: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a_s = 2'b10;
                alu_src_b_s = 2'b01;
            end
            S_MEMREAD: begin
                adr_src_s = 1'b1;
            end
            S_MEMWB: begin
                result_src_s = 2'b01;
                reg_write_s  = 1'b1;
            end
            S_MEMWRITE: begin
                adr_src_s   = 1'b1;
                mem_write_s = 1'b1;
            end
            S_EXECR: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = alu_decode(funct3, funct7b5);
            end
            S_EXECI: begin
                alu_src_a_s   = 2'b10;
                alu_src_b_s   = 2'b01;
                alu_control_s = alu_decode(funct3, 1'b0);
            end
            S_ALUWB: begin
                reg_write_s = 1'b1;
            end
            S_BEQ: begin
                alu_src_a_s   = 2'b10;
                alu_control_s = ALU_SUB;
                pc_write_s    = Zero;
            end
            S_JAL: begin
                alu_src_a_s = 2'b01;
                alu_src_b_s = 2'b10;
                pc_write_s  = 1'b1;
            end
            S_ILLEGAL: begin
                illegal_s = 1'b1;
            end
            default: begin
                illegal_s = 1'b0;
            end
        endcase
    end

    // Reset blanks every control output in the same cycle it is asserted.
    always_comb begin
        if (Reset) begin
            PCWrite       = 1'b0;
            IRWrite       = 1'b0;
            AdrSrc        = 1'b0;
            MemWrite      = 1'b0;
            RegWrite      = 1'b0;
            ALUSrcA       = 2'b00;
            ALUSrcB       = 2'b00;
            ResultSrc     = 2'b00;
            ALUControl    = 3'b000;
            illegal_instr = 1'b0;
        end else begin
            PCWrite       = pc_write_s;
            IRWrite       = ir_write_s;
            AdrSrc        = adr_src_s;
            MemWrite      = mem_write_s;
            RegWrite      = reg_write_s;
            ALUSrcA       = alu_src_a_s;
            ALUSrcB       = alu_src_b_s;
            ResultSrc     = result_src_s;
            ALUControl    = alu_control_s;
            illegal_instr = illegal_s;
        end
    end

    assign retired = retired_q;

endmodule

// File: tb/tb_unidad_control_multiciclo.sv
// Directed bench for unidad_control_multiciclo: walks each instruction class
// cycle by cycle and checks control words and the retired counter.
module tb_unidad_control_multiciclo;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7b5;
    logic       zero;
    logic       mem_ready;

    logic        pcw_a, irw_a, adr_a, mw_a, rw_a, ill_a;
    logic [1:0]  sa_a, sb_a, rs_a;
    logic [2:0]  alu_a;
    logic [15:0] ret_a;
    logic        pcw_b, irw_b, adr_b, mw_b, rw_b, ill_b;
    logic [1:0]  sa_b, sb_b, rs_b;
    logic [2:0]  alu_b;
    logic [3:0]  ret_b;

    logic [14:0] ctrl_a, ctrl_b;
    assign ctrl_a = {pcw_a, irw_a, adr_a, mw_a, rw_a, sa_a, sb_a, rs_a, alu_a, ill_a};
    assign ctrl_b = {pcw_b, irw_b, adr_b, mw_b, rw_b, sa_b, sb_b, rs_b, alu_b, ill_b};

    int checks = 0;
    int errors = 0;
    int ret_exp = 0;

    always #5 clk = ~clk;

    unidad_control_multiciclo #(.RET_W(16)) dut (
        .CLK(clk), .Reset(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw_a), .IRWrite(irw_a), .AdrSrc(adr_a), .MemWrite(mw_a), .RegWrite(rw_a),
        .ALUSrcA(sa_a), .ALUSrcB(sb_a), .ResultSrc(rs_a), .ALUControl(alu_a),
        .illegal_instr(ill_a), .retired(ret_a)
    );

    unidad_control_multiciclo #(.RET_W(4)) dut4 (
        .CLK(clk), .Reset(rst), .opcode(opcode), .funct3(funct3), .funct7b5(funct7b5),
        .Zero(zero), .mem_ready(mem_ready),
        .PCWrite(pcw_b), .IRWrite(irw_b), .AdrSrc(adr_b), .MemWrite(mw_b), .RegWrite(rw_b),
        .ALUSrcA(sa_b), .ALUSrcB(sb_b), .ResultSrc(rs_b), .ALUControl(alu_b),
        .illegal_instr(ill_b), .retired(ret_b)
    );

    // Control word layout: {PCWrite,IRWrite,AdrSrc,MemWrite,RegWrite,SrcA,SrcB,ResultSrc,ALUControl,illegal}
    function automatic logic [14:0] cw(input logic pc, input logic ir, input logic adr,
                                       input logic mw, input logic rw, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] rs,
                                       input logic [2:0] alu, input logic ill);
        return {pc, ir, adr, mw, rw, sa, sb, rs, alu, ill};
    endfunction

    localparam logic [14:0] C_ZERO    = 15'd0;
    localparam logic [14:0] C_FETCH   = cw(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    localparam logic [14:0] C_FSTALL  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b10, 2'b10, 3'b000, 1'b0);
    localparam logic [14:0] C_DECODE  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_MEMADR  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_MEMREAD = cw(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_MEMWB   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0);
    localparam logic [14:0] C_MEMWR   = cw(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_ALUWB   = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_BEQ_T   = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
    localparam logic [14:0] C_BEQ_NT  = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0);
    localparam logic [14:0] C_JAL     = cw(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'b01, 2'b10, 2'b00, 3'b000, 1'b0);
    localparam logic [14:0] C_ILLEGAL = cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_ctrl(input string tag, input logic [14:0] exp);
        check(tag, {17'd0, ctrl_a}, {17'd0, exp});
        check({tag, "_w4"}, {17'd0, ctrl_b}, {17'd0, exp});
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // One R/I instruction starting in FETCH; ends back in FETCH.
    task automatic run_alu(input string tag, input logic [6:0] op, input logic [2:0] f3,
                           input logic f7, input logic [14:0] exp_exec);
        opcode = op; funct3 = f3; funct7b5 = f7;
        #1;
        chk_ctrl({tag, "_fetch"}, C_FETCH);
        step(); chk_ctrl({tag, "_decode"}, C_DECODE);
        step(); chk_ctrl({tag, "_exec"}, exp_exec);
        step(); chk_ctrl({tag, "_aluwb"}, C_ALUWB);
        step(); ret_exp++;
        check({tag, "_retired"}, {16'd0, ret_a}, ret_exp);
    endtask

    initial begin
        rst = 1'b1; mem_ready = 1'b1; zero = 1'b0;
        opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b1;

        // Reset state
        step();
        chk_ctrl("rst_outputs", C_ZERO);
        check("rst_retired", {16'd0, ret_a}, 32'd0);
        rst = 1'b0;
        #1;

        // R-type sub
        chk_ctrl("sub_fetch", C_FETCH);
        step(); chk_ctrl("sub_decode", C_DECODE);
        step(); chk_ctrl("sub_execr", cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b001, 1'b0));
        step(); chk_ctrl("sub_aluwb", C_ALUWB);
        check("sub_ret_before", {16'd0, ret_a}, 32'd0);
        step(); ret_exp++;
        check("sub_retired", {16'd0, ret_a}, 32'd1);

        // FETCH stall then lw with 3 not-ready cycles in MEMREAD
        opcode = 7'b0000011; mem_ready = 1'b0; #1;
        chk_ctrl("fetch_stall", C_FSTALL);
        step(); chk_ctrl("fetch_stall2", C_FSTALL);
        mem_ready = 1'b1; #1;
        chk_ctrl("lw_fetch", C_FETCH);
        step(); chk_ctrl("lw_decode", C_DECODE);
        step(); chk_ctrl("lw_memadr", C_MEMADR);
        step(); mem_ready = 1'b0; #1; chk_ctrl("lw_memread1", C_MEMREAD);
        step(); chk_ctrl("lw_memread2", C_MEMREAD);
        step(); chk_ctrl("lw_memread3", C_MEMREAD);
        step(); mem_ready = 1'b1; #1; chk_ctrl("lw_memread4", C_MEMREAD);
        step(); chk_ctrl("lw_memwb", C_MEMWB);
        step(); ret_exp++;
        chk_ctrl("lw_back_fetch", C_FETCH);
        check("lw_retired", {16'd0, ret_a}, 32'd2);

        // beq taken then not taken
        opcode = 7'b1100011; zero = 1'b1;
        step(); chk_ctrl("beq1_decode", C_DECODE);
        step(); chk_ctrl("beq1_taken", C_BEQ_T);
        step(); ret_exp++; zero = 1'b0;
        check("beq1_retired", {16'd0, ret_a}, 32'd3);
        step(); chk_ctrl("beq2_decode", C_DECODE);
        step(); chk_ctrl("beq2_not_taken", C_BEQ_NT);
        step(); ret_exp++;
        check("beq2_retired", {16'd0, ret_a}, 32'd4);

        // Illegal opcode pulses in cycle 3 and retires nothing
        opcode = 7'b1111111; #1;
        chk_ctrl("ill_fetch", C_FETCH);
        step(); chk_ctrl("ill_decode", C_DECODE);
        step(); chk_ctrl("ill_pulse", C_ILLEGAL);
        step(); chk_ctrl("ill_cleared", C_FETCH);
        check("ill_retired", {16'd0, ret_a}, 32'd4);

        // sw with MemWrite held across not-ready cycles
        opcode = 7'b0100011;
        step(); chk_ctrl("sw_decode", C_DECODE);
        step(); chk_ctrl("sw_memadr", C_MEMADR);
        step(); mem_ready = 1'b0; #1; chk_ctrl("sw_memwrite1", C_MEMWR);
        step(); chk_ctrl("sw_memwrite2", C_MEMWR);
        check("sw_ret_waiting", {16'd0, ret_a}, 32'd4);
        mem_ready = 1'b1; #1; chk_ctrl("sw_memwrite3", C_MEMWR);
        step(); ret_exp++;
        chk_ctrl("sw_back_fetch", C_FETCH);
        check("sw_retired", {16'd0, ret_a}, 32'd5);

        // jal counted once, at ALUWB
        opcode = 7'b1101111;
        step(); chk_ctrl("jal_decode", C_DECODE);
        step(); chk_ctrl("jal_state", C_JAL);
        step(); chk_ctrl("jal_aluwb", C_ALUWB);
        check("jal_ret_mid", {16'd0, ret_a}, 32'd5);
        step(); ret_exp++;
        check("jal_retired", {16'd0, ret_a}, 32'd6);

        // ALU decode for R and I types
        run_alu("r_or",     7'b0110011, 3'b110, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b011, 1'b0));
        run_alu("r_slt",    7'b0110011, 3'b010, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b101, 1'b0));
        run_alu("r_and",    7'b0110011, 3'b111, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b010, 1'b0));
        run_alu("r_add",    7'b0110011, 3'b000, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0));
        run_alu("r_unsup",  7'b0110011, 3'b001, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0));
        run_alu("i_add_f7", 7'b0010011, 3'b000, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        run_alu("i_and",    7'b0010011, 3'b111, 1'b1, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b010, 1'b0));
        run_alu("i_or",     7'b0010011, 3'b110, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b011, 1'b0));
        run_alu("i_slt",    7'b0010011, 3'b010, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b101, 1'b0));
        run_alu("i_unsup",  7'b0010011, 3'b101, 1'b0, cw(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b10, 2'b01, 2'b00, 3'b000, 1'b0));
        check("alu_total_retired", {16'd0, ret_a}, 32'd16);

        // Reset asserted mid-MEMWRITE while memory is not ready
        opcode = 7'b0100011;
        step(); chk_ctrl("rsw_decode", C_DECODE);
        step(); chk_ctrl("rsw_memadr", C_MEMADR);
        step(); mem_ready = 1'b0; #1; chk_ctrl("rsw_memwrite", C_MEMWR);
        rst = 1'b1; #1;
        chk_ctrl("rsw_outputs_zero", C_ZERO);
        step(); chk_ctrl("rsw_held_zero", C_ZERO);
        check("rsw_retired", {16'd0, ret_a}, 32'd0);
        check("rsw_retired_w4", {28'd0, ret_b}, 32'd0);
        rst = 1'b0; mem_ready = 1'b1; #1;
        chk_ctrl("rsw_fetch", C_FETCH);
        step(); chk_ctrl("rsw_decode_again", C_DECODE);

        // Clean restart, then 17 R-types to wrap the 4-bit counter
        rst = 1'b1;
        step();
        rst = 1'b0; opcode = 7'b0110011; funct3 = 3'b000; funct7b5 = 1'b0; #1;
        chk_ctrl("wrap_fetch", C_FETCH);
        for (int i = 1; i <= 17; i++) begin
            step(); step(); step(); step();
            if (i == 16) check("wrap_zero_w4", {28'd0, ret_b}, 32'd0);
        end
        check("wrap_one_w4", {28'd0, ret_b}, 32'd1);
        check("wrap_17_w16", {16'd0, ret_a}, 32'd17);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
